stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl_if.sv | 22 ++
 rtl/stopwatch_ctrl.sv | 134 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Counter-side bus of the stopwatch: increment/clear controls going out,
// current BCD count (tens 0-5, ones 0-9) coming back from the counter.
interface stopwatch_ctrl_if;
  logic       cnt_en;
  logic       cnt_clr;
  logic [3:0] cnt_tens;
  logic [3:0] cnt_ones;

  modport master (
    output cnt_en,
    output cnt_clr,
    input  cnt_tens,
    input  cnt_ones
  );

  modport slave (
    input  cnt_en,
    input  cnt_clr,
    output cnt_tens,
    output cnt_ones
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop and lap/clear buttons drive an external
// 00-59 BCD counter, with lap hold, minute tally and auto-stop at a target.
module stopwatch_ctrl (
  input  logic                    clk_1,
  input  logic                    rst,
  input  logic                    btn_ss,
  input  logic                    btn_lap,
  input  logic                    tgt_en,
  input  logic [3:0]              tgt_tens,
  input  logic [3:0]              tgt_ones,
  stopwatch_ctrl_if.master        cnt_bus,
  output logic [3:0]              disp_tens,
  output logic [3:0]              disp_ones,
  output logic [5:0]              minutes,
  output logic                    done,
  output logic [2:0]              state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    LAP   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       ss_prev;
  logic       lap_prev;
  logic       ss_p;
  logic       lap_p;
  logic       hit;
  logic       at_59;
  logic       run_req;
  logic       clr_req;
  logic       lap_capture;
  logic       min_clr;
  logic [3:0] lap_tens;
  logic [3:0] lap_ones;

  assign ss_p  = btn_ss  & ~ss_prev;
  assign lap_p = btn_lap & ~lap_prev;
  assign hit   = tgt_en & (cnt_bus.cnt_tens == tgt_tens) & (cnt_bus.cnt_ones == tgt_ones);
  assign at_59 = (cnt_bus.cnt_tens == 4'd5) & (cnt_bus.cnt_ones == 4'd9);

  // Event priority inside every state is hit > ss_p > lap_p; losers are dropped.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nx    = state;
    run_req     = 1'b0;
    clr_req     = 1'b0;
    lap_capture = 1'b0;
    min_clr     = 1'b0;
    case (state)
      IDLE: begin
        if (ss_p)       state_nx = RUN;
        else if (lap_p) clr_req  = 1'b1;
      end
      RUN: begin
        run_req = ~hit;
        if (hit)        state_nx = DONE;
        else if (ss_p)  state_nx = PAUSE;
        else if (lap_p) begin
          state_nx    = LAP;
          lap_capture = 1'b1;
        end
      end
      LAP: begin
        run_req = ~hit;
        if (hit)        state_nx = DONE;
        else if (ss_p)  state_nx = PAUSE;
        else if (lap_p) state_nx = RUN;
      end
      PAUSE: begin
        if (ss_p)       state_nx = RUN;
        else if (lap_p) begin
          state_nx = IDLE;
          clr_req  = 1'b1;
          min_clr  = 1'b1;
        end
      end
      DONE: begin
        if (ss_p | lap_p) begin
          state_nx = IDLE;
          clr_req  = 1'b1;
          min_clr  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Reset masks every control output so nothing reaches the counter mid-reset.
  assign cnt_bus.cnt_en  = run_req & ~rst;
  assign cnt_bus.cnt_clr = clr_req & ~rst;
  assign done            = (state == DONE) & ~rst;
  assign state_o         = state;

  always_comb begin
    disp_tens = cnt_bus.cnt_tens;
    disp_ones = cnt_bus.cnt_ones;
    if ((state == LAP) && !rst) begin
      disp_tens = lap_tens;
      disp_ones = lap_ones;
    end
  end

  // Button history resets high so a button held through reset is not a press.
  always_ff @(posedge clk_1) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample together.
    if (rst) begin
      state    <= IDLE;
      ss_prev  <= 1'b1;
      lap_prev <= 1'b1;
      lap_tens <= 4'd0;
      lap_ones <= 4'd0;
      minutes  <= 6'd0;
    end else begin
      state    <= state_nx;
      ss_prev  <= btn_ss;
      lap_prev <= btn_lap;
      if (lap_capture) begin
        lap_tens <= cnt_bus.cnt_tens;
        lap_ones <= cnt_bus.cnt_ones;
      end
      if (min_clr)
        minutes <= 6'd0;
      else if (cnt_bus.cnt_en && at_59 && (minutes != 6'd63))
        minutes <= minutes + 6'd1;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a BCD counter model closes the loop, and a
// numeric reference of the stopwatch rules predicts every output each cycle.
module tb_stopwatch_ctrl;

  logic       clk_1 = 1'b0;
  logic       rst;
  logic       btn_ss;
  logic       btn_lap;
  logic       tgt_en;
  logic [3:0] tgt_tens;
  logic [3:0] tgt_ones;
  logic [3:0] disp_tens;
  logic [3:0] disp_ones;
  logic [5:0] minutes;
  logic       done;
  logic [2:0] state_o;

  stopwatch_ctrl_if cnt_bus ();

  stopwatch_ctrl dut (
    .clk_1     (clk_1),
    .rst       (rst),
    .btn_ss    (btn_ss),
    .btn_lap   (btn_lap),
    .tgt_en    (tgt_en),
    .tgt_tens  (tgt_tens),
    .tgt_ones  (tgt_ones),
    .cnt_bus   (cnt_bus.master),
    .disp_tens (disp_tens),
    .disp_ones (disp_ones),
    .minutes   (minutes),
    .done      (done),
    .state_o   (state_o)
  );

  always #5 clk_1 = ~clk_1;

  // Controlled 00-59 BCD counter, reset together with the controller.
  logic [3:0] c_tens = 4'd0;
  logic [3:0] c_ones = 4'd0;
  assign cnt_bus.cnt_tens = c_tens;
  assign cnt_bus.cnt_ones = c_ones;

  always @(posedge clk_1) begin
    if (rst || cnt_bus.cnt_clr) begin
      c_tens <= 4'd0;
      c_ones <= 4'd0;
    end else if (cnt_bus.cnt_en) begin
      if (c_ones == 4'd9) begin
        c_ones <= 4'd0;
        c_tens <= (c_tens == 4'd5) ? 4'd0 : c_tens + 4'd1;
      end else begin
        c_ones <= c_ones + 4'd1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference state: mode uses the published numbering 0..4, -1 = not yet known.
  int m      = -1;
  int cnt_m  = 0;
  int mins_m = 0;
  int lapv_m = 0;
  bit pss_m  = 1'b1;
  bit plap_m = 1'b1;
  int tgt_val = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_tgt(input bit en, input int v);
    tgt_en   = en;
    tgt_val  = v;
    tgt_tens = 4'(v / 10);
    tgt_ones = 4'(v % 10);
  endtask

  // One clock cycle: apply buttons, check outputs mid-cycle, then advance the reference.
  task automatic step(input bit ss, input bit lp);
    bit ssp, lpp, hit_n, e_en, e_clr;
    int e_disp, nxt;
    btn_ss  = ss;
    btn_lap = lp;
    @(negedge clk_1);
    ssp    = ss && !pss_m;
    lpp    = lp && !plap_m;
    hit_n  = tgt_en && (cnt_m == tgt_val);
    e_en   = !rst && (m == 1 || m == 2) && !hit_n;
    e_clr  = !rst && ((m == 4 && (ssp || lpp)) || ((m == 0 || m == 3) && !ssp && lpp));
    e_disp = (!rst && m == 2) ? lapv_m : cnt_m;
    if (m >= 0) begin
      check("state", 8'(state_o), 8'(m));
      check("minutes", 8'(minutes), 8'(mins_m));
    end
    check("cnt_en", 8'(cnt_bus.cnt_en), 8'(e_en));
    check("cnt_clr", 8'(cnt_bus.cnt_clr), 8'(e_clr));
    check("done", 8'(done), 8'(!rst && m == 4));
    check("disp", 8'(disp_tens * 10 + disp_ones), 8'(e_disp));
    check("count", 8'(c_tens * 10 + c_ones), 8'(cnt_m));
    if (rst) begin
      m = 0; cnt_m = 0; mins_m = 0; lapv_m = 0; pss_m = 1'b1; plap_m = 1'b1;
    end else begin
      nxt = m;
      if (e_en && cnt_m == 59 && mins_m < 63) mins_m++;
      case (m)
        0: if (ssp) nxt = 1;
        1, 2: begin
          if (hit_n)     nxt = 4;
          else if (ssp)  nxt = 3;
          else if (lpp) begin
            nxt = (m == 1) ? 2 : 1;
            if (m == 1) lapv_m = cnt_m;
          end
        end
        3: if (ssp) nxt = 1; else if (lpp) begin nxt = 0; mins_m = 0; end
        4: if (ssp || lpp) begin nxt = 0; mins_m = 0; end
        default: nxt = 0;
      endcase
      if (e_clr)     cnt_m = 0;
      else if (e_en) cnt_m = (cnt_m + 1) % 60;
      m = nxt;
      pss_m  = ss;
      plap_m = lp;
    end
    @(posedge clk_1);
    #1;
  endtask

  initial begin
    int c;
    rst = 1'b1; btn_ss = 1'b0; btn_lap = 1'b0;
    set_tgt(1'b0, 0);

    // Start/stop held through reset must not register as a press.
    step(1, 0); step(1, 0);
    rst = 1'b0;
    step(1, 0); step(1, 0); step(0, 0);

    // Start, count to 23, take a lap, keep counting to 30, return to live view.
    step(1, 0);
    for (int i = 0; i < 100 && cnt_m != 23; i++) step(0, 0);
    step(0, 1);
    for (int i = 0; i < 100 && cnt_m != 30; i++) step(0, 0);
    step(0, 1);
    step(0, 0); step(0, 0);

    // Pause freezes the count; lap from pause clears to idle.
    step(1, 0);
    step(0, 0); step(0, 0); step(0, 0);
    step(0, 1);
    step(0, 0);

    // Auto-stop at 15, then start/stop leaves DONE with a clear.
    set_tgt(1'b1, 15);
    step(1, 0);
    for (int i = 0; i < 40 && m != 4; i++) step(0, 0);
    step(0, 0); step(0, 0);
    step(1, 0);
    step(0, 0);

    // Two full wraps give two minutes; pause + lap clears them.
    set_tgt(1'b0, 0);
    step(1, 0);
    for (int i = 0; i < 200 && mins_m != 2; i++) step(0, 0);
    step(0, 0); step(0, 0);
    step(1, 0);
    step(0, 0);
    step(0, 1);
    step(0, 0);

    // Coincident presses in RUN: start/stop wins, no lap capture.
    step(1, 0);
    for (int i = 0; i < 4; i++) step(0, 0);
    step(1, 1);
    step(0, 0);

    // Target hit on the same cycle as start/stop goes to DONE.
    c = (cnt_m + 4) % 60;
    set_tgt(1'b1, c);
    step(1, 0);
    for (int i = 0; i < 100 && cnt_m != tgt_val; i++) step(0, 0);
    step(1, 0);
    step(0, 0);
    step(0, 1);
    step(0, 0);

    // Target 00: start, then DONE on the next edge with no increment.
    set_tgt(1'b1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    step(0, 1);
    step(0, 0);
    set_tgt(1'b0, 0);

    // Reset asserted while showing a lap.
    step(1, 0);
    step(0, 0); step(0, 0); step(0, 0);
    step(0, 1);
    step(0, 0);
    rst = 1'b1;
    step(0, 0); step(0, 0);
    rst = 1'b0;
    step(0, 0);
    step(1, 0);
    step(0, 0); step(0, 0);
    step(0, 1);
    step(0, 0);
    step(0, 1);

    // Randomized traffic, including occasional reset and target changes.
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) set_tgt(1'($urandom_range(1)), int'($urandom_range(59)));
      rst = ($urandom_range(80) == 0);
      step(($urandom_range(5) == 0), ($urandom_range(6) == 0));
    end
    rst = 1'b0;
    step(0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
